wt_8b_mult: RTL and testbench

- 8x8 unsigned multiplier built as a Wallace-tree reduction of partial products, with a registered 16-bit product.
- Used as a benchmark datapath block for approximate-logic-synthesis experiments. The exact version defined here is the golden reference.
- Sits between an operand source and a result sink. Strict one-result-per-accepted-operand-pair flow.

---
 rtl/wt_mult_pkg.sv | 9 +
 rtl/wt_fa.sv | 16 +
 rtl/wt_8b_mult.sv | 153 +++++++++++++++
 tb/tb_wt_8b_mult.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/wt_mult_pkg.sv
// Shared widths and the product word type for the Wallace-tree 8x8 multiplier.
package wt_mult_pkg;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    typedef logic [PW-1:0] prod_t;

endpackage : wt_mult_pkg

// File: rtl/wt_fa.sv
// One-bit full adder; the only arithmetic cell used by the reduction tree and final adder.
module wt_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ab_x;

    assign ab_x = a ^ b;
    assign sum  = ab_x ^ cin;
    assign cout = (a & b) | (cin & ab_x);

endmodule : wt_fa

// File: rtl/wt_8b_mult.sv
// 8x8 unsigned multiplier: partial products, four 3:2 carry-save layers (8->6->4->3->2 rows),
// ripple carry-propagate adder and a registered 16-bit product with 1-cycle latency.
module wt_8b_mult
    import wt_mult_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in0,
    input  logic [W-1:0]  in1,
    output logic          out_valid,
    output logic [PW-1:0] out0
);

    // Rows are kept as full-width column vectors so each bit index is one column of the tree.
    prod_t l0 [8];
    prod_t l1 [6];
    prod_t l2 [4];
    prod_t l3 [3];
    prod_t l4 [2];
    prod_t product_next;
    prod_t product_reg;
    logic  valid_reg;

    // Partial products: row i holds in0 & in1[i], weighted by 2^i.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pp
        logic [W-1:0] pp_row;
        assign pp_row = in0 & {W{in1[gi]}};
        assign l0[gi] = prod_t'({{W{1'b0}}, pp_row}) << gi;
    end

    // Layer 1: two 3:2 groups on rows 0-5, rows 6-7 pass through.
    for (genvar gi = 0; gi < 2; gi++) begin : g_l1
        prod_t         s;
        logic [PW-2:0] c;
        for (genvar ci = 0; ci < PW; ci++) begin : g_col
            if (ci < PW - 1) begin : g_fa
                wt_fa u_fa (
                    .a    (l0[3*gi][ci]),
                    .b    (l0[3*gi+1][ci]),
                    .cin  (l0[3*gi+2][ci]),
                    .sum  (s[ci]),
                    .cout (c[ci])
                );
            end else begin : g_top
                // Carry out of the top column would be weight 2^16, which the product never reaches.
                assign s[ci] = l0[3*gi][ci] ^ l0[3*gi+1][ci] ^ l0[3*gi+2][ci];
            end
        end
        assign l1[2*gi]   = s;
        assign l1[2*gi+1] = {c, 1'b0};
    end
    assign l1[4] = l0[6];
    assign l1[5] = l0[7];

    // Layer 2: two 3:2 groups on rows 0-5.
    for (genvar gi = 0; gi < 2; gi++) begin : g_l2
        prod_t         s;
        logic [PW-2:0] c;
        for (genvar ci = 0; ci < PW; ci++) begin : g_col
            if (ci < PW - 1) begin : g_fa
                wt_fa u_fa (
                    .a    (l1[3*gi][ci]),
                    .b    (l1[3*gi+1][ci]),
                    .cin  (l1[3*gi+2][ci]),
                    .sum  (s[ci]),
                    .cout (c[ci])
                );
            end else begin : g_top
                assign s[ci] = l1[3*gi][ci] ^ l1[3*gi+1][ci] ^ l1[3*gi+2][ci];
            end
        end
        assign l2[2*gi]   = s;
        assign l2[2*gi+1] = {c, 1'b0};
    end

    // Layer 3: one 3:2 group on rows 0-2, row 3 passes through.
    for (genvar gi = 0; gi < 1; gi++) begin : g_l3
        prod_t         s;
        logic [PW-2:0] c;
        for (genvar ci = 0; ci < PW; ci++) begin : g_col
            if (ci < PW - 1) begin : g_fa
                wt_fa u_fa (
                    .a    (l2[0][ci]),
                    .b    (l2[1][ci]),
                    .cin  (l2[2][ci]),
                    .sum  (s[ci]),
                    .cout (c[ci])
                );
            end else begin : g_top
                assign s[ci] = l2[0][ci] ^ l2[1][ci] ^ l2[2][ci];
            end
        end
        assign l3[0] = s;
        assign l3[1] = {c, 1'b0};
    end
    assign l3[2] = l2[3];

    // Layer 4: final 3:2 group leaves two rows for the carry-propagate adder.
    for (genvar gi = 0; gi < 1; gi++) begin : g_l4
        prod_t         s;
        logic [PW-2:0] c;
        for (genvar ci = 0; ci < PW; ci++) begin : g_col
            if (ci < PW - 1) begin : g_fa
                wt_fa u_fa (
                    .a    (l3[0][ci]),
                    .b    (l3[1][ci]),
                    .cin  (l3[2][ci]),
                    .sum  (s[ci]),
                    .cout (c[ci])
                );
            end else begin : g_top
                assign s[ci] = l3[0][ci] ^ l3[1][ci] ^ l3[2][ci];
            end
        end
        assign l4[0] = s;
        assign l4[1] = {c, 1'b0};
    end

    // Ripple carry-propagate adder; bit 0 is a full adder with its carry-in tied low.
    logic [PW-1:0] fc;
    assign fc[0] = 1'b0;
    for (genvar ci = 0; ci < PW; ci++) begin : g_cpa
        if (ci < PW - 1) begin : g_fa
            wt_fa u_fa (
                .a    (l4[0][ci]),
                .b    (l4[1][ci]),
                .cin  (fc[ci]),
                .sum  (product_next[ci]),
                .cout (fc[ci+1])
            );
        end else begin : g_top
            assign product_next[ci] = l4[0][ci] ^ l4[1][ci] ^ fc[ci];
        end
    end

    // Product only loads on in_valid so idle cycles hold the last result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            product_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                product_reg <= product_next;
            end
        end
    end

    assign out0      = product_reg;
    assign out_valid = valid_reg;

endmodule : wt_8b_mult

// File: tb/tb_wt_8b_mult.sv
// Scoreboard bench for wt_8b_mult: expected products queued on drive, popped one cycle later.
module tb_wt_8b_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in0;
    logic [7:0]  in1;
    logic        out_valid;
    logic [15:0] out0;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;

    wt_8b_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out0      (out0)
    );

    always #5 clk = ~clk;

    // Drive one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic rn, input logic v, input logic [7:0] a, input logic [7:0] b);
        rst_n    = rn;
        in_valid = v;
        in0      = a;
        in1      = b;
        if (!rn) exp_q.delete();
        else if (v) exp_q.push_back(16'(a) * 16'(b));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 8'hFF, 8'hFF);
            checks++;
            if (out0 !== 16'h0000 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_%0d got out0=%h out_valid=%b want out0=0000 out_valid=0", k, out0, out_valid);
            end else $display("reset cycle %0d: out0=%h out_valid=%b", k, out0, out_valid);
        end
        drive(1'b1, 1'b1, 8'hFF, 8'hFF);
        checks++;
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (out_valid !== 1'b1 || out0 !== exp_v || out0 !== 16'hFE01) begin
            errors++;
            $display("FAIL reset_release got out0=%h out_valid=%b want out0=fe01 out_valid=1", out0, out_valid);
        end else $display("release: ff*ff -> %h", out0);
    endtask

    task automatic test_corners();
        logic [7:0]  ca [5] = '{8'd0, 8'd255, 8'd1,   8'd128, 8'd0};
        logic [7:0]  cb [5] = '{8'd0, 8'd255, 8'd200, 8'd2,   8'd173};
        logic [15:0] ce [5] = '{16'h0000, 16'hFE01, 16'h00C8, 16'h0100, 16'h0000};
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, ca[k], cb[k]);
            checks++;
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (out_valid !== 1'b1 || out0 !== exp_v || out0 !== ce[k]) begin
                errors++;
                $display("FAIL corner_%0d %0d*%0d got out0=%h out_valid=%b want out0=%h out_valid=1",
                         k, ca[k], cb[k], out0, out_valid, ce[k]);
            end else $display("corner %0d*%0d -> %h", ca[k], cb[k], out0);
        end
    endtask

    task automatic test_patterns();
        logic [7:0]  pa [3] = '{8'hAA, 8'h55, 8'd200};
        logic [7:0]  pb [3] = '{8'h55, 8'hAA, 8'd100};
        logic [15:0] pe [3] = '{16'h3872, 16'h3872, 16'h4E20};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, pa[k], pb[k]);
            checks++;
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (out_valid !== 1'b1 || out0 !== exp_v || out0 !== pe[k]) begin
                errors++;
                $display("FAIL pattern_%0d %h*%h got out0=%h out_valid=%b want out0=%h out_valid=1",
                         k, pa[k], pb[k], out0, out_valid, pe[k]);
            end else $display("pattern %h*%h -> %h", pa[k], pb[k], out0);
        end
    endtask

    task automatic test_valid_gaps();
        logic        gv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0]  ga [4] = '{8'd3, 8'd0, 8'd0, 8'd7};
        logic [7:0]  gb [4] = '{8'd5, 8'd0, 8'd0, 8'd9};
        logic [15:0] ge [4] = '{16'd15, 16'd15, 16'd15, 16'd63};
        for (int k = 0; k < 4; k++) begin
            // Operands on idle cycles are junk and must not reach out0.
            if (gv[k]) drive(1'b1, 1'b1, ga[k], gb[k]);
            else drive(1'b1, 1'b0, 8'($urandom), 8'($urandom));
            checks++;
            exp_v = ge[k];
            if (gv[k]) exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (out_valid !== gv[k] || out0 !== exp_v || out0 !== ge[k]) begin
                errors++;
                $display("FAIL gap_%0d got out0=%0d out_valid=%b want out0=%0d out_valid=%b",
                         k, out0, out_valid, ge[k], gv[k]);
            end else $display("gap step %0d: out0=%0d out_valid=%b", k, out0, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic       mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] ma [7] = '{8'd12, 8'd250, 8'd77, 8'd99, 8'd255, 8'd16, 8'd3};
        logic [7:0] mb [7] = '{8'd34, 8'd251, 8'd201, 8'd99, 8'd1, 8'd16, 8'd0};
        for (int k = 0; k < 7; k++) begin
            drive(mr[k], 1'b1, ma[k], mb[k]);
            checks++;
            if (!mr[k]) begin
                if (out0 !== 16'h0000 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_%0d got out0=%h out_valid=%b want out0=0000 out_valid=0",
                             k, out0, out_valid);
                end else $display("mid-stream reset: out0=%h out_valid=%b", out0, out_valid);
            end else begin
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                if (out_valid !== 1'b1 || out0 !== exp_v) begin
                    errors++;
                    $display("FAIL midreset_%0d %0d*%0d got out0=%h out_valid=%b want out0=%h out_valid=1",
                             k, ma[k], mb[k], out0, out_valid, exp_v);
                end else $display("stream %0d*%0d -> %h", ma[k], mb[k], out0);
            end
        end
    endtask

    task automatic test_exhaustive();
        int bad;
        for (int i = 0; i < 256; i++) begin
            bad = 0;
            for (int j = 0; j < 256; j++) begin
                drive(1'b1, 1'b1, 8'(i), 8'(j));
                checks++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                if (out_valid !== 1'b1 || out0 !== exp_v) begin
                    errors++;
                    bad++;
                    if (bad <= 2)
                        $display("FAIL sweep %0d*%0d got out0=%h out_valid=%b want out0=%h out_valid=1",
                                 i, j, out0, out_valid, exp_v);
                end
            end
            $display("sweep in0=%0d: 256 products, %0d wrong", i, bad);
        end
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain got pending=%0d out_valid=%b want pending=0 out_valid=0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in0      = 8'h00;
        in1      = 8'h00;
        test_reset();
        test_corners();
        test_patterns();
        test_valid_gaps();
        test_mid_reset();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wt_8b_mult
